fsk_modulator: RTL

- Binary FSK modulator placed directly downstream of the serial ENCODER.
- Accepts one coded bit at a time through a valid/ready handshake.
- Emits a square-wave carrier for exactly BIT_CYCLES clocks per bit: frequency F1 for bit 1, F0 for bit 0.
- Its output feeds the channel/demodulator path ahead of the DECODER.

---
 rtl/fsk_modulator_if.sv | 21 ++
 rtl/fsk_modulator.sv | 113 +++++++++++
 2 files changed

// File: rtl/fsk_modulator_if.sv
// Bit handshake from the encoder plus the modulated-carrier status outputs.
// master: encoder / stimulus side, drives bit_in and bit_valid.
// slave: modulator side, answers with bit_ready and drives the carrier outputs.
interface fsk_modulator_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic fsk_out;
  logic busy;
  logic sym_start;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, fsk_out, busy, sym_start
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, fsk_out, busy, sym_start
  );
endinterface

// File: rtl/fsk_modulator.sv
// Binary FSK modulator: one coded bit in, BIT_CYCLES clocks of square-wave carrier out.
// Latency: the symbol starts on the clock after the transfer; back-to-back bits are gapless.
// Backpressure: bit_ready is high only when idle or in the last cycle of the current symbol.
module fsk_modulator #(
  parameter int BIT_CYCLES = 16,
  parameter int DIV_F0     = 4,
  parameter int DIV_F1     = 2
) (
  input  logic           clk,
  input  logic           reset,
  fsk_modulator_if.slave bus
);

  localparam int DIV_MAX = (DIV_F0 > DIV_F1) ? DIV_F0 : DIV_F1;
  localparam int SYM_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int HALF_W  = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [SYM_W-1:0]  SYM_LAST = SYM_W'(BIT_CYCLES - 1);
  localparam logic [HALF_W-1:0] F0_LAST  = HALF_W'(DIV_F0 - 1);
  localparam logic [HALF_W-1:0] F1_LAST  = HALF_W'(DIV_F1 - 1);

  // Illegal configurations are rejected while the design is elaborated.
  if (BIT_CYCLES < 2 || DIV_F0 < 1 || DIV_F1 < 1) begin : g_cfg_err
    $error("fsk_modulator: illegal configuration (BIT_CYCLES>=2, DIV_F0>=1, DIV_F1>=1)");
  end

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state;
  logic [SYM_W-1:0]    sym_cnt;
  logic [HALF_W-1:0]   half_cnt;
  logic                cur_bit;
  logic                fsk_q;
  logic                busy_q;
  logic                sym_start_q;

  logic                last_cycle;
  logic                xfer;
  logic [HALF_W-1:0]   half_last;

  // Accept a new bit when idle or exactly on the final clock of the running symbol.
  assign last_cycle    = (state == SEND) && (sym_cnt == SYM_LAST);
  assign bus.bit_ready = (state == IDLE) || last_cycle;
  assign xfer          = bus.bit_valid && bus.bit_ready;
  assign half_last     = cur_bit ? F1_LAST : F0_LAST;

  assign bus.fsk_out   = fsk_q;
  assign bus.busy      = busy_q;
  assign bus.sym_start = sym_start_q;

  // Symbol sequencing and carrier generation; the carrier level is never forced
  // at a symbol boundary, only the half-period counter restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sym_cnt     <= '0;
      half_cnt    <= '0;
      cur_bit     <= 1'b0;
      fsk_q       <= 1'b0;
      busy_q      <= 1'b0;
      sym_start_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sym_start_q <= 1'b0;
          if (xfer) begin
            cur_bit     <= bus.bit_in;
            sym_cnt     <= '0;
            half_cnt    <= '0;
            state       <= SEND;
            busy_q      <= 1'b1;
            sym_start_q <= 1'b1;
          end
        end

        SEND: begin
          // A toggle that falls due on the last cycle still happens.
          if (half_cnt == half_last) begin
            fsk_q    <= ~fsk_q;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + HALF_W'(1);
          end

          if (!last_cycle) begin
            sym_cnt     <= sym_cnt + SYM_W'(1);
            sym_start_q <= 1'b0;
          end else if (xfer) begin
            // Reload for a gapless next symbol; any partial half-period is dropped.
            cur_bit     <= bus.bit_in;
            sym_cnt     <= '0;
            half_cnt    <= '0;
            sym_start_q <= 1'b1;
          end else begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            sym_start_q <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          sym_start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
